// File: rtl/ipf_lcu_feeder_if.sv
// Pixel stream bus from the LCU feeder to the IPF filter.
// The feeder drives pixel, per-LCU parameters and done; the filter drives busy.
interface ipf_lcu_feeder_if;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
  logic        done;
  logic        busy;

  modport master (
    output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done,
    input  busy
  );

  modport slave (
    input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done,
    output busy
  );
endinterface

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 image LCU by LCU from image/parameter ROMs to the IPF filter,
// honouring busy back-pressure through a one-pixel holding register.
module ipf_lcu_feeder #(
  parameter int LCU_SIZE = 16,
  parameter int LOG_SIZE = 4,
  parameter int LCU_NUM  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [13:0] img_addr,
  input  logic [7:0]  img_data,
  output logic [5:0]  par_addr,
  input  logic [23:0] par_data,
  ipf_lcu_feeder_if.master bus
);

  localparam int PX      = 2 * LOG_SIZE;
  localparam int LB      = $clog2(LCU_NUM);
  localparam int CNT_W   = PX + 2 * LB;
  localparam int PIX_NUM = LCU_SIZE * LCU_SIZE * LCU_NUM * LCU_NUM;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PIX_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_STREAM, S_STALL, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_iss;       // stream index of the next address to issue
  logic [CNT_W-1:0] r_out;       // stream index of the next pixel to deliver
  logic             r_prime;
  logic             r_hold_vld;
  logic [7:0]       r_hold_pix;
  logic [23:0]      r_hold_par;
  logic [13:0]      r_img_addr;
  logic [5:0]       r_par_addr;
  logic             r_in_en;
  logic [7:0]       r_din;
  logic [23:0]      r_par;
  logic [2:0]       r_lcu_x;
  logic [2:0]       r_lcu_y;
  logic             r_done;

  logic             w_have;
  logic             w_first;
  logic             w_last;
  logic [7:0]       w_src_pix;
  logic [23:0]      w_src_par;
  logic [13:0]      w_iss_addr;

  // Both ROMs share the same latency and are addressed in lockstep, so the
  // ROM outputs always describe one pixel and its LCU's parameters together.
  assign w_iss_addr = {r_iss[CNT_W-1 -: LB], r_iss[PX-1 -: LOG_SIZE],
                       r_iss[PX +: LB], r_iss[LOG_SIZE-1:0]};
  assign w_have     = r_hold_vld | ~r_prime;
  assign w_first    = (r_out[PX-1:0] == '0);
  assign w_last     = (r_out == LAST);
  assign w_src_pix  = r_hold_vld ? r_hold_pix : img_data;
  assign w_src_par  = r_hold_vld ? r_hold_par : par_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_iss      <= '0;
      r_out      <= '0;
      r_prime    <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold_pix <= '0;
      r_hold_par <= '0;
      r_img_addr <= '0;
      r_par_addr <= '0;
      r_in_en    <= 1'b0;
      r_din      <= '0;
      r_par      <= '0;
      r_lcu_x    <= '0;
      r_lcu_y    <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_en <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            r_out      <= '0;
            r_hold_vld <= 1'b0;
            r_state    <= S_PREP;
          end
        end
        S_PREP: begin
          r_in_en    <= 1'b0;
          r_img_addr <= '0;
          r_par_addr <= '0;
          r_iss      <= CNT_W'(1);
          r_prime    <= 1'b1;
          r_state    <= S_STREAM;
        end
        S_STREAM: begin
          // The first cycle after PREP has no valid ROM data yet (r_prime).
          r_img_addr <= w_iss_addr;
          r_par_addr <= r_iss[CNT_W-1 -: 2*LB];
          r_iss      <= r_iss + CNT_W'(1);
          r_prime    <= 1'b0;
          r_hold_vld <= 1'b0;
          r_in_en    <= w_have;
          if (w_have) begin
            r_din <= w_src_pix;
            r_out <= r_out + CNT_W'(1);
            if (w_first) begin
              r_par   <= w_src_par;
              r_lcu_x <= r_out[PX +: LB];
              r_lcu_y <= r_out[CNT_W-1 -: LB];
            end
          end
          if (w_have && w_last) begin
            r_state <= S_DONE;
          end else if (bus.busy) begin
            r_state <= S_STALL;
          end
        end
        S_STALL: begin
          // Address is frozen here, so the ROM output during the first stall
          // cycle is the pixel that would have gone out next; keep it.
          r_in_en <= 1'b0;
          if (!r_hold_vld) begin
            r_hold_vld <= 1'b1;
            r_hold_pix <= img_data;
            r_hold_par <= par_data;
          end
          if (!bus.busy) begin
            r_state <= S_STREAM;
          end
        end
        S_DONE: begin
          r_in_en <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign img_addr         = r_img_addr;
  assign par_addr         = r_par_addr;
  assign bus.in_en        = r_in_en;
  assign bus.din          = r_din;
  assign bus.ipf_type     = r_par[23:22];
  assign bus.ipf_band_pos = r_par[21:17];
  assign bus.ipf_wo_class = r_par[16];
  assign bus.ipf_offset   = r_par[15:0];
  assign bus.lcu_x        = r_lcu_x;
  assign bus.lcu_y        = r_lcu_y;
  assign bus.lcu_size     = 2'd0;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Bench for ipf_lcu_feeder: ROM models, a stream-order reference model checked
// every delivery, and directed start/busy/reset scenarios.
module tb_ipf_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] img_addr;
  logic [7:0]  img_data;
  logic [5:0]  par_addr;
  logic [23:0] par_data;

  ipf_lcu_feeder_if bus ();

  ipf_lcu_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .img_addr (img_addr),
    .img_data (img_data),
    .par_addr (par_addr),
    .par_data (par_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  img_rom [16384];
  logic [23:0] par_rom [64];

  always @(posedge clk) begin
    img_data <= img_rom[img_addr];
    par_data <= par_rom[par_addr];
  end

  int n_err    = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stream index k -> image address: LCUs raster, pixels row-major inside.
  function automatic logic [13:0] addr_of(input int k);
    int lcu = k / 256;
    int row = (k / 16) % 16;
    int col = k % 16;
    return 14'((lcu / 8) * 2048 + row * 128 + (lcu % 8) * 16 + col);
  endfunction

  function automatic logic [37:0] exp_vec(input int k);
    return {img_rom[addr_of(k)], par_rom[k / 256], 3'((k / 256) % 8), 3'(k / 2048)};
  endfunction

  function automatic logic [37:0] obs_now();
    return {bus.din, bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
            bus.lcu_x, bus.lcu_y};
  endfunction

  function automatic logic [63:0] outs_now();
    return {2'b00, img_addr, par_addr, bus.in_en, bus.din, bus.ipf_type, bus.ipf_band_pos,
            bus.ipf_wo_class, bus.ipf_offset, bus.lcu_x, bus.lcu_y, bus.lcu_size, bus.done};
  endfunction

  task automatic load_roms(input bit hashed);
    for (int a = 0; a < 16384; a++)
      img_rom[a] = hashed ? 8'((a * 37) ^ (a >> 6)) : 8'(a);
    for (int i = 0; i < 64; i++)
      par_rom[i] = {2'(i), 5'(i * 3), 1'(i), 16'(i * 4951)};
  endtask

  // Reference monitor: every delivery must be the next pixel of the stream.
  int          exp_k    = 0;
  int          gap      = 0;
  int          last_gap = 0;
  int          since    = 99;
  int          done_cnt = 0;
  logic [29:0] last_par = '0;
  logic [37:0] obs;

  always @(negedge clk) begin
    if (reset) begin
      exp_k    = 0;
      gap      = 0;
      since    = 99;
      last_par = '0;
    end else begin
      obs = obs_now();
      if (bus.in_en) begin
        check("pixel", 64'(obs), 64'(exp_vec(exp_k)));
        last_par = obs[29:0];
        exp_k++;
        last_gap = gap;
        gap      = 0;
        since    = 0;
      end else begin
        check("param_hold", 64'(obs[29:0]), 64'(last_par));
        gap++;
        since++;
      end
      if (bus.done) begin
        check("done_count", exp_k, 16384);
        check("done_after_last", since, 1);
        done_cnt++;
        exp_k = 0;
      end
    end
  end

  task automatic pulse_start(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (bus.in_en) break;
    end
  endtask

  task automatic wait_pix(input int p);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus.in_en && exp_k == p) && n < 40000);
    check("reach_pixel", exp_k, p);
  endtask

  task automatic wait_del();
    int n = 0;
    while (!bus.in_en && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40000) begin
      @(posedge clk); #1;
      n++;
    end
    check("saw_done", bus.done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int run;
    reset    = 1'b1;
    start    = 1'b0;
    bus.busy = 1'b0;
    load_roms(1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", outs_now(), 64'd0);

    // Run 1: no back-pressure, image = address[7:0].
    pulse_start(lat);
    check("run1_latency", lat, 3);
    run = 0;
    while (bus.in_en && run < 20000) begin
      if (run == 17)   check("pin_pix17", bus.din, 8'h81);
      if (run == 255)  check("pin_pix255", bus.din, 8'h8F);
      if (run == 256)  check("pin_pix256", {bus.din, bus.lcu_x, bus.lcu_y}, {8'h10, 3'd1, 3'd0});
      if (run == 2048) check("pin_pix2048", {bus.din, bus.lcu_x, bus.lcu_y}, {8'h00, 3'd0, 3'd1});
      run++;
      @(posedge clk); #1;
    end
    check("run1_contiguous", run, 16384);
    check("run1_done", bus.done, 1);
    repeat (3) @(posedge clk);
    #1;

    // Run 2: hashed image, stalls, ignored start, parameter entry 9.
    load_roms(1'b1);
    par_rom[9] = {2'd2, 5'd12, 1'b1, 16'h1F3A};
    pulse_start(lat);
    check("run2_latency", lat, 3);

    wait_pix(300);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    wait_pix(2046);
    bus.busy = 1'b1;
    @(posedge clk); #1;
    bus.busy = 1'b0;
    @(posedge clk); #1;
    wait_del();
    check("lcu_boundary_gap", last_gap, 1);
    check("lcu_boundary_next", exp_k, 2049);
    check("lcu_boundary_pix", {bus.din, bus.lcu_x, bus.lcu_y}, {8'h20, 3'd0, 3'd1});

    wait_pix(2309);
    check("entry9_params", {bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
                            bus.lcu_x, bus.lcu_y}, {2'd2, 5'd12, 1'b1, 16'h1F3A, 3'd1, 3'd1});

    wait_pix(6755);
    bus.busy = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.busy = 1'b0;
    wait_del();
    check("stall5_gap", last_gap, 5);
    check("stall5_next", exp_k, 6758);

    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 2);

    // Run 3: reset in mid-stream, then a clean restart.
    pulse_start(lat);
    check("run3_latency", lat, 3);
    wait_pix(5000);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_outputs", outs_now(), 64'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume", {bus.in_en, img_addr}, 15'd0);
    pulse_start(lat);
    check("restart_latency", lat, 3);
    check("restart_first", {exp_k, bus.din, bus.lcu_x, bus.lcu_y}, {32'd0, 8'h00, 3'd0, 3'd0});
    wait_pix(600);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("done_pulses_final", done_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
